// File: rtl/register_file_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// register_file_scoreboard_pkg
//   Shared defaults and types for the multi-port register file.
//   - Default geometry (data width, select width, read port count).
//   - Program-counter placement and step.
//   - Per-register next-value source encoding used by the write-priority logic.
// ----------------------------------------------------------------------------
package register_file_scoreboard_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 4;
   localparam int unsigned DEF_NUM_READ   = 3;
   localparam int unsigned DEF_PC_INDEX   = 15;
   localparam int unsigned DEF_PC_STEP    = 4;
   localparam int unsigned DEF_BYPASS     = 1;

   // Where a register takes its next value from at the coming edge.
   // The priority between these sources is A > B > PC increment > hold.
   typedef enum logic [1:0] {
      SRC_HOLD   = 2'd0,
      SRC_PORT_A = 2'd1,
      SRC_PORT_B = 2'd2,
      SRC_PC_INC = 2'd3
   } reg_src_e;

   // Resolve the next-value source for one register from its decoded strobes.
   function automatic reg_src_e pick_source(input logic hit_a,
                                            input logic hit_b,
                                            input logic pc_inc);
      reg_src_e src;
      src = SRC_HOLD;
      if (hit_a) begin
         src = SRC_PORT_A;
      end else if (hit_b) begin
         src = SRC_PORT_B;
      end else if (pc_inc) begin
         src = SRC_PC_INC;
      end
      return src;
   endfunction

endpackage

// File: rtl/register_file_scoreboard_read_port.sv
// ----------------------------------------------------------------------------
// register_read_port
//   One combinational read port of the register file.
//   Ports:
//     select          register index being read
//     storage         stored register values (all registers)
//     busy            per-register scoreboard bits
//     write_a_*       port A write strobe/select/data of the current cycle
//     write_b_*       port B write strobe/select/data of the current cycle
//     data            read value (optionally forwarded from a pending write)
//     busy_out        scoreboard bit of the selected register
//   With BYPASS != 0 a write landing on the selected register this cycle is
//   forwarded (A before B), and a port B write also hides the busy bit since
//   the load it stands for is completing right now.
// ----------------------------------------------------------------------------
module register_read_port
   import register_file_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_REGS   = 2**DEF_ADDR_WIDTH,
   parameter int unsigned BYPASS     = DEF_BYPASS
) (
   input  logic [ADDR_WIDTH-1:0] select,
   input  logic [DATA_WIDTH-1:0] storage [NUM_REGS],
   input  logic [NUM_REGS-1:0]   busy,
   input  logic                  write_a_enable,
   input  logic [ADDR_WIDTH-1:0] write_a_select,
   input  logic [DATA_WIDTH-1:0] write_a_data,
   input  logic                  write_b_enable,
   input  logic [ADDR_WIDTH-1:0] write_b_select,
   input  logic [DATA_WIDTH-1:0] write_b_data,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  busy_out
);

   localparam logic FORWARD = (BYPASS != 0);

   logic hit_a;
   logic hit_b;

   assign hit_a = FORWARD && write_a_enable && (write_a_select == select);
   assign hit_b = FORWARD && write_b_enable && (write_b_select == select);

   always_comb begin
      data = storage[select];
      if (hit_a) begin
         data = write_a_data;
      end else if (hit_b) begin
         data = write_b_data;
      end
   end

   assign busy_out = busy[select] & ~hit_b;

endmodule

// File: rtl/register_file_scoreboard.sv
// ----------------------------------------------------------------------------
// register_file_scoreboard
//   Parametrised register file with NUM_READ combinational read ports, two
//   write ports (A = execute result, B = memory writeback), a program counter
//   living in register PC_INDEX, and a per-register busy scoreboard.
//   Ports:
//     clk, reset_n        rising-edge clock, synchronous active-low reset
//     read_select         packed selects, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     read_data           packed read data, same packing
//     read_busy           busy bit of each read port's selected register
//     write_a_*           port A write (wins over B on the same register)
//     write_b_*           port B write, also retires the busy bit
//     reserve_*           marks a register busy (load issued)
//     pc_increment        PC += PC_STEP unless PC is written this cycle
//     pc_out              stored PC value, never forwarded
// ----------------------------------------------------------------------------
module register_file_scoreboard
   import register_file_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_READ   = DEF_NUM_READ,
   parameter int unsigned PC_INDEX   = DEF_PC_INDEX,
   parameter int unsigned PC_STEP    = DEF_PC_STEP,
   parameter int unsigned BYPASS     = DEF_BYPASS
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] read_select,
   output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
   output logic [NUM_READ-1:0]            read_busy,
   input  logic                           write_a_enable,
   input  logic [ADDR_WIDTH-1:0]          write_a_select,
   input  logic [DATA_WIDTH-1:0]          write_a_data,
   input  logic                           write_b_enable,
   input  logic [ADDR_WIDTH-1:0]          write_b_select,
   input  logic [DATA_WIDTH-1:0]          write_b_data,
   input  logic                           reserve_enable,
   input  logic [ADDR_WIDTH-1:0]          reserve_select,
   input  logic                           pc_increment,
   output logic [DATA_WIDTH-1:0]          pc_out
);

   localparam int unsigned     NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_SEL = ADDR_WIDTH'(PC_INDEX);
   localparam logic [DATA_WIDTH-1:0] PC_ADD = DATA_WIDTH'(PC_STEP);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_next;
   logic [NUM_REGS-1:0]   hit_a;
   logic [NUM_REGS-1:0]   hit_b;
   reg_src_e              src [NUM_REGS];

   // One-hot decode of each write port's destination.
   assign hit_a = write_a_enable ? (NUM_REGS'(1) << write_a_select) : '0;
   assign hit_b = write_b_enable ? (NUM_REGS'(1) << write_b_select) : '0;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         src[i] = pick_source(hit_a[i], hit_b[i],
                              (i == int'(PC_INDEX)) && pc_increment);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            case (src[i])
               SRC_PORT_A: regs[i] <= write_a_data;
               SRC_PORT_B: regs[i] <= write_b_data;
               SRC_PC_INC: regs[i] <= regs[i] + PC_ADD;
               default:    regs[i] <= regs[i];
            endcase
         end
      end
   end

   // Clear first, then set: a reserve on the register being written back
   // means a new load has been issued and must stay outstanding.
   always_comb begin
      busy_next = busy;
      if (write_b_enable) begin
         busy_next[write_b_select] = 1'b0;
      end
      if (reserve_enable && (reserve_select != PC_SEL)) begin
         busy_next[reserve_select] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign pc_out = regs[PC_INDEX];

   for (genvar p = 0; p < NUM_READ; p++) begin : g_read
      register_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .NUM_REGS   (NUM_REGS),
         .BYPASS     (BYPASS)
      ) u_read_port (
         .select         (read_select[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .storage        (regs),
         .busy           (busy),
         .write_a_enable (write_a_enable),
         .write_a_select (write_a_select),
         .write_a_data   (write_a_data),
         .write_b_enable (write_b_enable),
         .write_b_select (write_b_select),
         .write_b_data   (write_b_data),
         .data           (read_data[p*DATA_WIDTH +: DATA_WIDTH]),
         .busy_out       (read_busy[p])
      );
   end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_register_file_scoreboard
//   Drives a forwarding (BYPASS=1) and a non-forwarding (BYPASS=0) instance
//   with identical stimulus and compares both against an array-based model.
// ----------------------------------------------------------------------------
module tb_register_file_scoreboard;

   localparam int DW   = 32;
   localparam int AW   = 4;
   localparam int NR   = 3;
   localparam int NREG = 16;
   localparam int PCI  = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset_n;
   logic [NR*AW-1:0]     read_select;
   logic                 write_a_enable, write_b_enable, reserve_enable, pc_increment;
   logic [AW-1:0]        write_a_select, write_b_select, reserve_select;
   logic [DW-1:0]        write_a_data, write_b_data;

   logic [NR*DW-1:0]     rd_byp, rd_nob;
   logic [NR-1:0]        busy_byp, busy_nob;
   logic [DW-1:0]        pc_byp, pc_nob;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_regs [NREG];
   bit            m_busy [NREG];

   register_file_scoreboard #(.BYPASS(1)) u_dut_byp (
      .clk(clk), .reset_n(reset_n), .read_select(read_select),
      .read_data(rd_byp), .read_busy(busy_byp),
      .write_a_enable(write_a_enable), .write_a_select(write_a_select), .write_a_data(write_a_data),
      .write_b_enable(write_b_enable), .write_b_select(write_b_select), .write_b_data(write_b_data),
      .reserve_enable(reserve_enable), .reserve_select(reserve_select),
      .pc_increment(pc_increment), .pc_out(pc_byp)
   );

   register_file_scoreboard #(.BYPASS(0)) u_dut_nob (
      .clk(clk), .reset_n(reset_n), .read_select(read_select),
      .read_data(rd_nob), .read_busy(busy_nob),
      .write_a_enable(write_a_enable), .write_a_select(write_a_select), .write_a_data(write_a_data),
      .write_b_enable(write_b_enable), .write_b_select(write_b_select), .write_b_data(write_b_data),
      .reserve_enable(reserve_enable), .reserve_select(reserve_select),
      .pc_increment(pc_increment), .pc_out(pc_nob)
   );

   // Reference model: what a read should return right now.
   function automatic logic [DW-1:0] exp_data(int sel, bit byp);
      if (byp && write_a_enable && int'(write_a_select) == sel) return write_a_data;
      if (byp && write_b_enable && int'(write_b_select) == sel) return write_b_data;
      return m_regs[sel];
   endfunction

   function automatic bit exp_busy(int sel, bit byp);
      if (byp && write_b_enable && int'(write_b_select) == sel) return 1'b0;
      return m_busy[sel];
   endfunction

   // Reference model: state after the edge. Later assignments override
   // earlier ones, giving A over B over increment.
   task automatic model_update();
      logic [DW-1:0] nxt [NREG];
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         nxt = m_regs;
         if (pc_increment)   nxt[PCI] = m_regs[PCI] + 32'd4;
         if (write_b_enable) nxt[write_b_select] = write_b_data;
         if (write_a_enable) nxt[write_a_select] = write_a_data;
         m_regs = nxt;
         if (write_b_enable) m_busy[write_b_select] = 1'b0;
         if (reserve_enable && int'(reserve_select) != PCI) m_busy[reserve_select] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      reset_n        = 1'b1;
      write_a_enable = 1'b0;
      write_b_enable = 1'b0;
      reserve_enable = 1'b0;
      pc_increment   = 1'b0;
   endtask

   task automatic set_sel(int p, int r);
      read_select[p*AW +: AW] = AW'(r);
   endtask

   task automatic test_reset();
      idle();
      read_select    = '0;
      write_a_select = 4'd3; write_a_data = 32'hDEAD;
      write_b_select = 4'd4; write_b_data = 32'hBEEF;
      reserve_select = 4'd2;
      reset_n        = 1'b0;
      write_a_enable = 1'b1;
      write_b_enable = 1'b1;
      reserve_enable = 1'b1;
      pc_increment   = 1'b1;
      tick();
      idle();
      for (int r = 0; r < NREG; r++) begin
         for (int p = 0; p < NR; p++) set_sel(p, r);
         #1;
         for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd_byp[p*DW +: DW] !== 32'h0 || rd_nob[p*DW +: DW] !== 32'h0) begin
               errors++;
               $display("FAIL reset_data r%0d p%0d: got %h/%h want 0", r, p, rd_byp[p*DW +: DW], rd_nob[p*DW +: DW]);
            end
            checks++;
            if (busy_byp[p] !== 1'b0 || busy_nob[p] !== 1'b0) begin
               errors++;
               $display("FAIL reset_busy r%0d p%0d: got %b/%b want 0", r, p, busy_byp[p], busy_nob[p]);
            end
         end
      end
      checks++;
      if (pc_byp !== 32'h0 || pc_nob !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc: got %h/%h want 0", pc_byp, pc_nob);
      end
   endtask

   task automatic test_collision();
      idle();
      set_sel(0, 3);
      write_a_enable = 1'b1; write_a_select = 4'd3; write_a_data = 32'h11;
      write_b_enable = 1'b1; write_b_select = 4'd3; write_b_data = 32'h22;
      #1;
      checks++;
      if (rd_byp[0 +: DW] !== 32'h11) begin
         errors++;
         $display("FAIL collision_bypass: got %h want 11", rd_byp[0 +: DW]);
      end
      checks++;
      if (rd_nob[0 +: DW] !== exp_data(3, 0)) begin
         errors++;
         $display("FAIL collision_nobypass: got %h want %h", rd_nob[0 +: DW], exp_data(3, 0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_byp[0 +: DW] !== 32'h11 || rd_nob[0 +: DW] !== 32'h11) begin
         errors++;
         $display("FAIL collision_stored: got %h/%h want 11", rd_byp[0 +: DW], rd_nob[0 +: DW]);
      end
   endtask

   task automatic test_sweep();
      idle();
      for (int k = 0; k < 15; k++) begin
         write_a_enable = 1'b1; write_a_select = AW'(k); write_a_data = DW'(k);
         tick();
      end
      idle();
      for (int k = 0; k < 15; k += 2) begin
         set_sel(0, k);
         set_sel(1, k + 1);
         #1;
         checks++;
         if (rd_byp[0 +: DW] !== DW'(k)) begin
            errors++;
            $display("FAIL sweep_even r%0d: got %h want %h", k, rd_byp[0 +: DW], DW'(k));
         end
         if (k + 1 < 15) begin
            checks++;
            if (rd_byp[DW +: DW] !== DW'(k + 1)) begin
               errors++;
               $display("FAIL sweep_odd r%0d: got %h want %h", k + 1, rd_byp[DW +: DW], DW'(k + 1));
            end
         end
      end
   endtask

   task automatic test_scoreboard();
      idle();
      reserve_enable = 1'b1; reserve_select = 4'd5;
      tick();
      idle();
      set_sel(2, 5);
      #1;
      checks++;
      if (busy_byp[2] !== 1'b1 || busy_nob[2] !== 1'b1) begin
         errors++;
         $display("FAIL sb_reserved: got %b/%b want 1", busy_byp[2], busy_nob[2]);
      end
      write_b_enable = 1'b1; write_b_select = 4'd5; write_b_data = 32'h50;
      #1;
      checks++;
      if (busy_byp[2] !== 1'b0 || rd_byp[2*DW +: DW] !== 32'h50) begin
         errors++;
         $display("FAIL sb_writeback_bypass: got busy %b data %h want 0 50", busy_byp[2], rd_byp[2*DW +: DW]);
      end
      checks++;
      if (busy_nob[2] !== exp_busy(5, 0) || rd_nob[2*DW +: DW] !== exp_data(5, 0)) begin
         errors++;
         $display("FAIL sb_writeback_nobypass: got busy %b data %h want %b %h", busy_nob[2], rd_nob[2*DW +: DW], exp_busy(5, 0), exp_data(5, 0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_byp[2*DW +: DW] !== 32'h50 || busy_byp[2] !== 1'b0 || busy_nob[2] !== 1'b0) begin
         errors++;
         $display("FAIL sb_retired: got %h busy %b/%b want 50 0", rd_byp[2*DW +: DW], busy_byp[2], busy_nob[2]);
      end
      reserve_enable = 1'b1; reserve_select = 4'd5;
      write_b_enable = 1'b1; write_b_select = 4'd5; write_b_data = 32'h51;
      tick();
      idle();
      #1;
      checks++;
      if (busy_byp[2] !== 1'b1 || busy_nob[2] !== 1'b1) begin
         errors++;
         $display("FAIL sb_set_wins: got %b/%b want 1", busy_byp[2], busy_nob[2]);
      end
      reserve_enable = 1'b1; reserve_select = 4'd15;
      tick();
      idle();
      set_sel(2, 15);
      #1;
      checks++;
      if (busy_byp[2] !== 1'b0) begin
         errors++;
         $display("FAIL sb_pc_reserve: got %b want 0", busy_byp[2]);
      end
   endtask

   task automatic test_pc();
      idle();
      write_a_enable = 1'b1; write_a_select = 4'd15; write_a_data = 32'h0;
      tick();
      idle();
      pc_increment = 1'b1;
      repeat (3) tick();
      idle();
      checks++;
      if (pc_byp !== 32'd12 || pc_nob !== 32'd12) begin
         errors++;
         $display("FAIL pc_increment: got %h/%h want c", pc_byp, pc_nob);
      end
      write_a_enable = 1'b1; write_a_select = 4'd15; write_a_data = 32'h100;
      pc_increment = 1'b1;
      tick();
      idle();
      checks++;
      if (pc_byp !== 32'h100) begin
         errors++;
         $display("FAIL pc_write_priority: got %h want 100", pc_byp);
      end
      write_b_enable = 1'b1; write_b_select = 4'd15; write_b_data = 32'hFFFF_FFFC;
      tick();
      idle();
      pc_increment = 1'b1;
      tick();
      idle();
      checks++;
      if (pc_byp !== 32'h0 || pc_nob !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap: got %h/%h want 0", pc_byp, pc_nob);
      end
   endtask

   task automatic test_nobypass();
      idle();
      set_sel(0, 10);
      write_a_enable = 1'b1; write_a_select = 4'd10; write_a_data = 32'd50;
      #1;
      checks++;
      if (rd_nob[0 +: DW] !== 32'd10 || rd_byp[0 +: DW] !== 32'd50) begin
         errors++;
         $display("FAIL nob_old_value: got %h/%h want a/32", rd_nob[0 +: DW], rd_byp[0 +: DW]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_nob[0 +: DW] !== 32'd50) begin
         errors++;
         $display("FAIL nob_new_value: got %h want 32", rd_nob[0 +: DW]);
      end
      reset_n = 1'b0;
      write_a_enable = 1'b1; write_a_select = 4'd10; write_a_data = 32'd77;
      tick();
      idle();
      #1;
      checks++;
      if (rd_nob[0 +: DW] !== 32'd0 || rd_byp[0 +: DW] !== 32'd0) begin
         errors++;
         $display("FAIL nob_reset: got %h/%h want 0", rd_nob[0 +: DW], rd_byp[0 +: DW]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset_n        = ($urandom_range(0, 49) != 0);
         read_select    = NR*AW'($urandom);
         write_a_enable = $urandom_range(0, 1) == 1;
         write_a_select = AW'($urandom);
         write_a_data   = $urandom;
         write_b_enable = $urandom_range(0, 1) == 1;
         write_b_select = AW'($urandom);
         write_b_data   = $urandom;
         reserve_enable = $urandom_range(0, 1) == 1;
         reserve_select = AW'($urandom);
         pc_increment   = $urandom_range(0, 1) == 1;
         #1;
         for (int p = 0; p < NR; p++) begin
            int s;
            s = int'(read_select[p*AW +: AW]);
            checks++;
            if (rd_byp[p*DW +: DW] !== exp_data(s, 1) || busy_byp[p] !== exp_busy(s, 1)) begin
               errors++;
               $display("FAIL rand_byp n%0d p%0d r%0d: got %h/%b want %h/%b", n, p, s, rd_byp[p*DW +: DW], busy_byp[p], exp_data(s, 1), exp_busy(s, 1));
            end
            checks++;
            if (rd_nob[p*DW +: DW] !== exp_data(s, 0) || busy_nob[p] !== exp_busy(s, 0)) begin
               errors++;
               $display("FAIL rand_nob n%0d p%0d r%0d: got %h/%b want %h/%b", n, p, s, rd_nob[p*DW +: DW], busy_nob[p], exp_data(s, 0), exp_busy(s, 0));
            end
         end
         checks++;
         if (pc_byp !== m_regs[PCI] || pc_nob !== m_regs[PCI]) begin
            errors++;
            $display("FAIL rand_pc n%0d: got %h/%h want %h", n, pc_byp, pc_nob, m_regs[PCI]);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      read_select    = '0;
      write_a_select = '0; write_a_data = '0;
      write_b_select = '0; write_b_data = '0;
      reserve_select = '0;
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      test_reset();
      test_collision();
      test_sweep();
      test_scoreboard();
      test_pc();
      test_nobypass();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
